// File: rtl/wm_plant_model.sv
// Washing-machine plant model: turns controller actuator outputs into its sensor inputs.
// Define WM_PLANT_CHECK_EN to add the sticky overflow_err / lock_err protocol checkers.
module wm_plant_model #(
    parameter int unsigned LEVEL_MAX   = 8,
    parameter int unsigned DET_CYCLES  = 2,
    parameter int unsigned WASH_CYCLES = 4,
    parameter int unsigned SPIN_CYCLES = 4,
    parameter int unsigned CNT_W       = 8,
    localparam int unsigned LVL_W      = $clog2(LEVEL_MAX + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             user_close,
    input  logic             door_lock,
    input  logic             fill_value_on,
    input  logic             drain_value_on,
    input  logic             motor_on,
    input  logic             soap_wash,
    input  logic             water_wash,
    input  logic             done,
    output logic             door_close,
    output logic             filled,
    output logic             drained,
    output logic             detergent_added,
    output logic             cycle_timeout,
    output logic             spin_timeout,
    output logic [LVL_W-1:0] level,
    output logic [2:0]       phase
`ifdef WM_PLANT_CHECK_EN
    ,
    output logic             overflow_err,
    output logic             lock_err
`endif
);

    typedef enum logic [2:0] {
        PH_IDLE  = 3'd0,
        PH_FILL  = 3'd1,
        PH_SOAP  = 3'd2,
        PH_WASH  = 3'd3,
        PH_DRAIN = 3'd4,
        PH_SPIN  = 3'd5
    } phase_e;

    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(LEVEL_MAX);
    localparam logic [CNT_W-1:0] T_DET    = CNT_W'(DET_CYCLES);
    localparam logic [CNT_W-1:0] T_WASH   = CNT_W'(WASH_CYCLES);
    localparam logic [CNT_W-1:0] T_SPIN   = CNT_W'(SPIN_CYCLES);

    phase_e             phase_q, phase_d;
    logic [LVL_W-1:0]   level_q, level_d;
    logic [CNT_W-1:0]   timer_q, timer_d;
    logic [CNT_W-1:0]   tgt_c;
    logic               door_q, door_d;
    logic               filled_q, filled_d;
    logic               drained_q, drained_d;
    logic               det_q, det_d;
    logic               cto_q, cto_d;
    logic               sto_q, sto_d;
    logic               quiet_q, quiet_d;
    logic               quiet_c;

    // water_wash is a monitored-only input with no effect on plant state
    logic unused_water_wash;
    assign unused_water_wash = water_wash;

    always_comb begin
        door_d    = door_lock ? (door_q | user_close) : user_close;
        level_d   = level_q;
        phase_d   = phase_q;
        timer_d   = timer_q;
        quiet_d   = 1'b0;
        det_d     = det_q;
        cto_d     = cto_q;
        sto_d     = sto_q;
        tgt_c     = '0;
        quiet_c   = ~(fill_value_on | drain_value_on | motor_on | soap_wash);

        if (fill_value_on && !drain_value_on && door_q) begin
            if (level_q != LVL_FULL) level_d = level_q + LVL_W'(1);
        end else if (drain_value_on && !fill_value_on) begin
            if (level_q != '0) level_d = level_q - LVL_W'(1);
        end

        unique case (phase_q)
            PH_IDLE:  if (fill_value_on && door_q)        phase_d = PH_FILL;
            PH_FILL:  if (filled_q && soap_wash)          phase_d = PH_SOAP;
            PH_SOAP:  if (det_q && motor_on)              phase_d = PH_WASH;
            PH_WASH:  if (drain_value_on)                 phase_d = PH_DRAIN;
            PH_DRAIN: if (drained_q && motor_on)          phase_d = PH_SPIN;
            PH_SPIN:  if (done || (!motor_on && sto_q))   phase_d = PH_IDLE;
            default:                                      phase_d = PH_IDLE;
        endcase

        // Two consecutive all-quiet edges mean the controller walked away
        if (phase_q != PH_IDLE && quiet_c) begin
            if (quiet_q) phase_d = PH_IDLE;
            else         quiet_d = 1'b1;
        end

        unique case (phase_q)
            PH_SOAP: tgt_c = T_DET;
            PH_WASH: tgt_c = T_WASH;
            PH_SPIN: tgt_c = T_SPIN;
            default: tgt_c = '0;
        endcase

        if (phase_d != phase_q)  timer_d = '0;
        else if (timer_q < tgt_c) timer_d = timer_q + CNT_W'(1);

        if (phase_d == PH_SOAP && timer_d == T_DET)             det_d = 1'b1;
        else if (phase_d == PH_DRAIN || phase_d == PH_IDLE)     det_d = 1'b0;

        if (phase_d == PH_WASH && timer_d == T_WASH)            cto_d = 1'b1;
        else if (phase_d == PH_SPIN || phase_d == PH_IDLE)      cto_d = 1'b0;

        if (phase_d == PH_SPIN && timer_d == T_SPIN)            sto_d = 1'b1;
        else if (phase_d == PH_IDLE)                            sto_d = 1'b0;

        filled_d  = (level_d == LVL_FULL);
        drained_d = (level_d == '0);
    end

`ifdef WM_PLANT_CHECK_EN
    logic ovf_q, ovf_d;
    logic lck_q, lck_d;

    always_comb begin
        ovf_d = ovf_q | (fill_value_on & ((level_q == LVL_FULL) | drain_value_on));
        lck_d = lck_q | (motor_on & ~door_lock);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_q <= 1'b0;
            lck_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            lck_q <= lck_d;
        end
    end

    assign overflow_err = ovf_q;
    assign lock_err     = lck_q;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_q   <= PH_IDLE;
            level_q   <= '0;
            timer_q   <= '0;
            door_q    <= 1'b0;
            filled_q  <= 1'b0;
            drained_q <= 1'b1;
            det_q     <= 1'b0;
            cto_q     <= 1'b0;
            sto_q     <= 1'b0;
            quiet_q   <= 1'b0;
        end else begin
            phase_q   <= phase_d;
            level_q   <= level_d;
            timer_q   <= timer_d;
            door_q    <= door_d;
            filled_q  <= filled_d;
            drained_q <= drained_d;
            det_q     <= det_d;
            cto_q     <= cto_d;
            sto_q     <= sto_d;
            quiet_q   <= quiet_d;
        end
    end

    assign door_close      = door_q;
    assign filled          = filled_q;
    assign drained         = drained_q;
    assign detergent_added = det_q;
    assign cycle_timeout   = cto_q;
    assign spin_timeout    = sto_q;
    assign level           = level_q;
    assign phase           = phase_q;

endmodule

// File: tb/tb_wm_plant_model.sv
// Scoreboard bench for wm_plant_model: directed plant walk-through plus a randomized controller.
module tb_wm_plant_model;

    localparam int unsigned LEVEL_MAX   = 8;
    localparam int unsigned DET_CYCLES  = 2;
    localparam int unsigned WASH_CYCLES = 4;
    localparam int unsigned SPIN_CYCLES = 4;
    localparam int unsigned CNT_W       = 8;
    localparam int unsigned LW          = $clog2(LEVEL_MAX + 1);

    logic clk = 1'b0;
    logic reset, user_close, door_lock, fill, drain, motor, soap, water_wash, done;
    logic door_o, filled_o, drained_o, det_o, cto_o, sto_o;
    logic [LW-1:0] level_o;
    logic [2:0]    phase_o;
    logic          ovf_o, lck_o;

    wm_plant_model #(
        .LEVEL_MAX(LEVEL_MAX), .DET_CYCLES(DET_CYCLES), .WASH_CYCLES(WASH_CYCLES),
        .SPIN_CYCLES(SPIN_CYCLES), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .user_close(user_close), .door_lock(door_lock),
        .fill_value_on(fill), .drain_value_on(drain), .motor_on(motor),
        .soap_wash(soap), .water_wash(water_wash), .done(done),
        .door_close(door_o), .filled(filled_o), .drained(drained_o),
        .detergent_added(det_o), .cycle_timeout(cto_o), .spin_timeout(sto_o),
        .level(level_o),
`ifdef WM_PLANT_CHECK_EN
        .overflow_err(ovf_o), .lock_err(lck_o),
`endif
        .phase(phase_o)
    );

`ifndef WM_PLANT_CHECK_EN
    assign ovf_o = 1'b0;
    assign lck_o = 1'b0;
`endif

    always #5 clk = ~clk;

    typedef struct packed {
        logic          door, filled, drained, det, cto, sto;
        logic [LW-1:0] level;
        logic [2:0]    phase;
        logic          ovf, lck;
    } obs_t;

    obs_t exp_q[$];
    int checks = 0;
    int errors = 0;

    // Reference plant kept as plain integers and flags
    int m_level, m_phase, m_timer, m_quiet;
    bit m_door, m_det, m_cto, m_sto, m_ovf, m_lck;

    function automatic int target(input int ph);
        case (ph)
            2:       return DET_CYCLES;
            3:       return WASH_CYCLES;
            5:       return SPIN_CYCLES;
            default: return 0;
        endcase
    endfunction

    task automatic model_reset();
        m_level = 0; m_phase = 0; m_timer = 0; m_quiet = 0;
        m_door = 0; m_det = 0; m_cto = 0; m_sto = 0; m_ovf = 0; m_lck = 0;
    endtask

    task automatic model_step();
        bit quiet;
        int np;
        quiet = !(fill || drain || motor || soap);
        np = m_phase;
        case (m_phase)
            0: if (fill && m_door)                 np = 1;
            1: if (m_level == LEVEL_MAX && soap)   np = 2;
            2: if (m_det && motor)                 np = 3;
            3: if (drain)                          np = 4;
            4: if (m_level == 0 && motor)          np = 5;
            5: if (done || (!motor && m_sto))      np = 0;
            default: np = 0;
        endcase
        if (m_phase != 0 && quiet) begin
            m_quiet++;
            if (m_quiet >= 2) np = 0;
        end else begin
            m_quiet = 0;
        end
        if (np == 0) m_quiet = 0;
        if (np != m_phase)                    m_timer = 0;
        else if (m_timer < target(m_phase))   m_timer++;
        if (fill && (m_level == LEVEL_MAX || drain)) m_ovf = 1;
        if (motor && !door_lock)                     m_lck = 1;
        if (fill && !drain && m_door) m_level = (m_level < LEVEL_MAX) ? m_level + 1 : m_level;
        else if (drain && !fill)      m_level = (m_level > 0) ? m_level - 1 : 0;
        m_door = door_lock ? (m_door || user_close) : user_close;
        m_det  = (np == 2) ? (m_timer == DET_CYCLES)  : (np == 3) ? m_det : 1'b0;
        m_cto  = (np == 3) ? (m_timer == WASH_CYCLES) : (np == 4) ? m_cto : 1'b0;
        m_sto  = (np == 5) ? (m_timer == SPIN_CYCLES) : 1'b0;
        m_phase = np;
    endtask

    function automatic obs_t model_obs();
        obs_t o;
        o.door = m_door; o.det = m_det; o.cto = m_cto; o.sto = m_sto;
        o.filled  = (m_level == LEVEL_MAX);
        o.drained = (m_level == 0);
        o.level   = LW'(m_level);
        o.phase   = 3'(m_phase);
`ifdef WM_PLANT_CHECK_EN
        o.ovf = m_ovf; o.lck = m_lck;
`else
        o.ovf = 1'b0;  o.lck = 1'b0;
`endif
        return o;
    endfunction

    function automatic obs_t dut_obs();
        obs_t o;
        o.door = door_o; o.filled = filled_o; o.drained = drained_o; o.det = det_o;
        o.cto = cto_o; o.sto = sto_o; o.level = level_o; o.phase = phase_o;
        o.ovf = ovf_o; o.lck = lck_o;
        return o;
    endfunction

    // Monitor: one comparison per clock edge for every queued expectation
    initial begin
        obs_t e, a;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = dut_obs();
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL scoreboard @%0t got door=%0d filled=%0d drained=%0d det=%0d cto=%0d sto=%0d level=%0d phase=%0d ovf=%0d lck=%0d expected door=%0d filled=%0d drained=%0d det=%0d cto=%0d sto=%0d level=%0d phase=%0d ovf=%0d lck=%0d",
                             $time, a.door, a.filled, a.drained, a.det, a.cto, a.sto, a.level, a.phase, a.ovf, a.lck,
                             e.door, e.filled, e.drained, e.det, e.cto, e.sto, e.level, e.phase, e.ovf, e.lck);
                end
            end
        end
    end

    task automatic expect_now(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s @%0t got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic set_act(input bit f, input bit d, input bit m, input bit s, input bit dn);
        fill = f; drain = d; motor = m; soap = s; done = dn;
    endtask

    task automatic tick();
        if (reset) model_reset();
        else       model_step();
        exp_q.push_back(model_obs());
        @(posedge clk);
        #2;
    endtask

    task automatic expect_reset_values(input string tag);
        expect_now({tag, "_door"},    int'(door_o),    0);
        expect_now({tag, "_filled"},  int'(filled_o),  0);
        expect_now({tag, "_drained"}, int'(drained_o), 1);
        expect_now({tag, "_det"},     int'(det_o),     0);
        expect_now({tag, "_cto"},     int'(cto_o),     0);
        expect_now({tag, "_sto"},     int'(sto_o),     0);
        expect_now({tag, "_level"},   int'(level_o),   0);
        expect_now({tag, "_phase"},   int'(phase_o),   0);
        expect_now({tag, "_ovf"},     int'(ovf_o),     0);
    endtask

    // Fill to full, dispense soap, then run the wash timer out
    task automatic reach_wash();
        set_act(1, 0, 0, 0, 0); tick();
        expect_now("enter_fill", int'(phase_o), 1);
        repeat (7) tick();
        expect_now("full_level", int'(level_o), LEVEL_MAX);
        expect_now("filled", int'(filled_o), 1);
        repeat (3) tick();
        expect_now("fill_saturate", int'(level_o), LEVEL_MAX);
        set_act(0, 0, 0, 1, 0); tick();
        expect_now("enter_soap", int'(phase_o), 2);
        expect_now("det_early0", int'(det_o), 0);
        tick();
        expect_now("det_early1", int'(det_o), 0);
        tick();
        expect_now("det_set", int'(det_o), 1);
        set_act(0, 0, 1, 0, 0); tick();
        expect_now("enter_wash", int'(phase_o), 3);
        repeat (3) tick();
        expect_now("cto_early", int'(cto_o), 0);
        tick();
        expect_now("cto_set", int'(cto_o), 1);
    endtask

    initial begin
        int r;
        reset = 1'b1; user_close = 1'b0; door_lock = 1'b0; water_wash = 1'b0;
        set_act(0, 0, 0, 0, 0);
        model_reset();
        @(posedge clk);
        #2;
        expect_reset_values("por");
        reset = 1'b0;

        user_close = 1'b1; door_lock = 1'b1; tick();
        expect_now("door_close", int'(door_o), 1);
        user_close = 1'b0; tick();
        expect_now("door_locked_hold", int'(door_o), 1);
        door_lock = 1'b0; tick();
        expect_now("door_unlock_open", int'(door_o), 0);
        user_close = 1'b1; door_lock = 1'b1; tick();

        reach_wash();
        set_act(0, 1, 0, 0, 0); tick();
        expect_now("enter_drain", int'(phase_o), 4);
        expect_now("cto_hold_drain", int'(cto_o), 1);
        repeat (6) tick();
        expect_now("drained_early", int'(drained_o), 0);
        tick();
        expect_now("drained_set", int'(drained_o), 1);
        set_act(0, 0, 1, 0, 0); tick();
        expect_now("enter_spin", int'(phase_o), 5);
        expect_now("cto_clear_spin", int'(cto_o), 0);
        repeat (3) tick();
        expect_now("sto_early", int'(sto_o), 0);
        tick();
        expect_now("sto_set", int'(sto_o), 1);
        set_act(0, 0, 0, 0, 1); tick();
        expect_now("done_idle", int'(phase_o), 0);
        expect_now("done_sto_clear", int'(sto_o), 0);

        reach_wash();
        #1 reset = 1'b1;
        #1 expect_reset_values("midwash");
        tick();
        reset = 1'b0;
        set_act(0, 0, 0, 0, 0); tick();

        set_act(1, 0, 0, 0, 0); repeat (4) tick();
        expect_now("half_level", int'(level_o), 4);
        set_act(1, 1, 0, 0, 0); tick();
        expect_now("both_valves_hold", int'(level_o), 4);
`ifdef WM_PLANT_CHECK_EN
        expect_now("ovf_set", int'(ovf_o), 1);
`endif
        set_act(0, 0, 0, 0, 0); tick();
        expect_now("quiet_one_edge", int'(phase_o), 1);
        tick();
        expect_now("quiet_abandon", int'(phase_o), 0);
`ifdef WM_PLANT_CHECK_EN
        expect_now("ovf_sticky", int'(ovf_o), 1);
        door_lock = 1'b0; set_act(0, 0, 1, 0, 0); tick();
        expect_now("lock_err_set", int'(lck_o), 1);
        door_lock = 1'b1;
`endif

        repeat (3000) begin
            user_close = 1'b1; door_lock = 1'b1; water_wash = 1'($urandom);
            set_act(0, 0, 0, 0, 0);
            case (m_phase)
                0: fill = 1'b1;
                1: if (m_level == LEVEL_MAX) soap = 1'b1; else fill = 1'b1;
                2: begin soap = 1'b1; motor = m_det; end
                3: begin motor = 1'b1; drain = m_cto; end
                4: begin drain = (m_level != 0); motor = (m_level == 0); end
                5: begin motor = !m_sto; done = m_sto && 1'($urandom); end
                default: ;
            endcase
            r = int'($urandom_range(0, 99));
            if (r < 6)        {fill, drain, motor, soap, done} = 5'($urandom);
            else if (r < 10)  set_act(0, 0, 0, 0, 0);
            if ($urandom_range(0, 19) == 0) user_close = 1'($urandom);
            if ($urandom_range(0, 19) == 0) door_lock  = 1'($urandom);
            if ($urandom_range(0, 399) == 0) reset = 1'b1;
            tick();
            reset = 1'b0;
        end

        set_act(0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_queue got %0d pending expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
